// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states, sign extension.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package exec_pkg;

  // Opcodes are compared against a zero-extended 32-bit copy of the opcode field,
  // so the block works for any opcode width.
  localparam logic [31:0] OP_ADD  = 32'd0;
  localparam logic [31:0] OP_SUB  = 32'd1;
  localparam logic [31:0] OP_AND  = 32'd2;
  localparam logic [31:0] OP_OR   = 32'd3;
  localparam logic [31:0] OP_XOR  = 32'd4;
  localparam logic [31:0] OP_SLL  = 32'd5;
  localparam logic [31:0] OP_SRL  = 32'd6;
  localparam logic [31:0] OP_ADDI = 32'd7;
  localparam logic [31:0] OP_CMP  = 32'd8;
  localparam logic [31:0] OP_BR   = 32'd9;
  localparam logic [31:0] OP_MUL  = 32'd10;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  // Sign-extend the low 'width' bits of val to 64 bits; callers truncate to their width.
  function automatic logic [63:0] sext(input logic [63:0] val, input int width);
    logic [63:0] mask;
    mask = ~64'd0 << width;
    return val[width-1] ? (val | mask) : (val & ~mask);
  endfunction

endpackage

// File: rtl/execute_unit_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low DATA_W bits kept.
// Latency: DATA_W cycles after start; product is combinational while done is high.
// Backpressure: stall holds the final step (done stays high) until the result is taken.
module mul_iter
  import exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] step_sum;
  logic [CW-1:0]     cnt;

  // The final step's addend is folded in combinationally so the result can be
  // registered downstream on the same edge as the last iteration.
  assign step_sum = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CW'(DATA_W - 1));
  assign product  = step_sum;

  // Latch operands on start, then advance one bit per cycle; hold on a stalled final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (busy && !(done && stall)) begin
      acc    <= step_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: combinational ALU, branch target and flags into a registered output stage.
// Latency: 1 cycle for single-cycle ops, DATA_W cycles for MUL.
// Backpressure: in_ready drops while MUL iterates or while a held result is not consumed.
module execute_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5,
  parameter int IMM_W  = 7,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   control_in,
  input  logic [IDX_W-1:0]  dest_index_in,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  input  logic [DATA_W-1:0] npc,
  input  logic [IMM_W-1:0]  immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   control_out,
  output logic [IDX_W-1:0]  dest_index_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] target,
  output logic              dest_reg_write_en,
  output logic              zf,
  output logic              gf,
  output logic              lf
);

  localparam int SHW = $clog2(DATA_W);

  state_t            state;
  state_t            state_nx;
  logic [31:0]       op32;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] alu_tgt;
  logic              alu_we;
  logic              alu_flg;
  logic              is_mul;
  logic              accept;
  logic              stall;
  logic              ld_alu;
  logic              ld_mul;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;
  logic [OP_W-1:0]   mul_ctl;
  logic [IDX_W-1:0]  mul_dst;
  logic [DATA_W-1:0] mul_npc;

  assign stall    = out_valid && !out_ready;
  assign in_ready = (state == IDLE) && !mul_busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign op32     = 32'(control_in);
  assign is_mul   = (op32 == OP_MUL);
  assign ld_alu   = accept && !is_mul;
  assign ld_mul   = (state == MUL_BUSY) && mul_done && !stall;

  // Single-cycle ALU, branch target, write enable and flag-update select.
  always_comb begin
    imm_ext = DATA_W'(sext(64'(immediate), IMM_W));
    alu_res = '0;
    alu_tgt = npc;
    alu_we  = 1'b0;
    alu_flg = 1'b0;
    case (op32)
      OP_ADD:  begin alu_res = reg1_data + reg2_data;               alu_we = 1'b1; end
      OP_SUB:  begin alu_res = reg1_data - reg2_data;               alu_we = 1'b1; alu_flg = 1'b1; end
      OP_AND:  begin alu_res = reg1_data & reg2_data;               alu_we = 1'b1; end
      OP_OR:   begin alu_res = reg1_data | reg2_data;               alu_we = 1'b1; end
      OP_XOR:  begin alu_res = reg1_data ^ reg2_data;               alu_we = 1'b1; end
      OP_SLL:  begin alu_res = reg1_data << reg2_data[SHW-1:0];     alu_we = 1'b1; end
      OP_SRL:  begin alu_res = reg1_data >> reg2_data[SHW-1:0];     alu_we = 1'b1; end
      OP_ADDI: begin alu_res = reg1_data + imm_ext;                 alu_we = 1'b1; end
      OP_CMP:  begin alu_res = reg1_data - reg2_data;               alu_flg = 1'b1; end
      OP_BR:   begin alu_tgt = npc + imm_ext; end
      default: ;
    endcase
  end

  // Two-state FSM: leave IDLE on an accepted MUL, return once its result is registered.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept && is_mul) state_nx = MUL_BUSY;
      MUL_BUSY: if (ld_mul) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Side-band fields of an in-flight MUL, captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_ctl <= '0;
      mul_dst <= '0;
      mul_npc <= '0;
    end else if (accept && is_mul) begin
      mul_ctl <= control_in;
      mul_dst <= dest_index_in;
      mul_npc <= npc;
    end
  end

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .stall   (stall),
    .a       (reg1_data),
    .b       (reg2_data),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Output register: a load wins over a consume, so load+consume keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      control_out       <= '0;
      dest_index_out    <= '0;
      result_out        <= '0;
      target            <= '0;
      dest_reg_write_en <= 1'b0;
      zf                <= 1'b0;
      gf                <= 1'b0;
      lf                <= 1'b0;
    end else if (ld_alu) begin
      out_valid         <= 1'b1;
      control_out       <= control_in;
      dest_index_out    <= dest_index_in;
      result_out        <= alu_res;
      target            <= alu_tgt;
      dest_reg_write_en <= alu_we;
      if (alu_flg) begin
        zf <= (reg1_data == reg2_data);
        gf <= ($signed(reg1_data) > $signed(reg2_data));
        lf <= ($signed(reg1_data) < $signed(reg2_data));
      end
    end else if (ld_mul) begin
      out_valid         <= 1'b1;
      control_out       <= mul_ctl;
      dest_index_out    <= mul_dst;
      result_out        <= mul_prod;
      target            <= mul_npc;
      dest_reg_write_en <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: ALU ops, flags, branch, MUL timing, backpressure, reset.
// Latency: expectations are sampled 1 time unit after the rising edge.
// Backpressure: out_ready is driven per scenario; acceptance waits are bounded.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  control_in = '0;
  logic [4:0]  dest_index_in = '0;
  logic [15:0] reg1_data = '0;
  logic [15:0] reg2_data = '0;
  logic [15:0] npc = '0;
  logic [6:0]  immediate = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  control_out;
  logic [4:0]  dest_index_out;
  logic [15:0] result_out;
  logic [15:0] target;
  logic        dest_reg_write_en;
  logic        zf, gf, lf;

  int checks = 0;
  int failures = 0;
  int consumed = 0;

  execute_unit #(.DATA_W(16), .IDX_W(5), .IMM_W(7), .OP_W(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .control_in        (control_in),
    .dest_index_in     (dest_index_in),
    .reg1_data         (reg1_data),
    .reg2_data         (reg2_data),
    .npc               (npc),
    .immediate         (immediate),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .control_out       (control_out),
    .dest_index_out    (dest_index_out),
    .result_out        (result_out),
    .target            (target),
    .dest_reg_write_en (dest_reg_write_en),
    .zf                (zf),
    .gf                (gf),
    .lf                (lf)
  );

  always #5 clk = ~clk;

  // Count output handshakes to detect dropped or duplicated results.
  always @(posedge clk) if (out_valid && out_ready) consumed++;

  // Present one instruction and hold it until the edge that accepts it (bounded).
  task automatic issue(input logic [4:0] op, input logic [4:0] dst, input logic [15:0] r1,
                       input logic [15:0] r2, input logic [15:0] n, input logic [6:0] imm);
    int w;
    control_in = op; dest_index_in = dst; reg1_data = r1; reg2_data = r2;
    npc = n; immediate = imm; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_accept in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (result_out !== 16'h0) begin failures++; $display("FAIL rst_result got=%h exp=0000", result_out); end
    checks++; if ({zf, gf, lf} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {zf, gf, lf}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sub;
    issue(5'd1, 5'd2, 16'd10, 16'd3, 16'h0004, 7'h0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sub_valid got=%0b exp=1", out_valid); end
    checks++; if (result_out !== 16'd7) begin failures++; $display("FAIL sub_result got=%0d exp=7", result_out); end
    checks++; if (dest_index_out !== 5'd2) begin failures++; $display("FAIL sub_dest got=%0d exp=2", dest_index_out); end
    checks++; if (dest_reg_write_en !== 1'b1) begin failures++; $display("FAIL sub_we got=%0b exp=1", dest_reg_write_en); end
    checks++; if ({zf, gf, lf} !== 3'b010) begin failures++; $display("FAIL sub_flags got=%b exp=010", {zf, gf, lf}); end
  endtask

  task automatic test_add_cmp;
    issue(5'd0, 5'd3, 16'hFFFF, 16'h0001, 16'h0020, 7'h0);
    checks++; if (result_out !== 16'h0000) begin failures++; $display("FAIL add_wrap got=%h exp=0000", result_out); end
    checks++; if ({zf, gf, lf} !== 3'b010) begin failures++; $display("FAIL add_flags_held got=%b exp=010", {zf, gf, lf}); end
    checks++; if (target !== 16'h0020) begin failures++; $display("FAIL add_target got=%h exp=0020", target); end
    issue(5'd8, 5'd4, 16'd5, 16'd5, 16'h0024, 7'h0);
    checks++; if ({zf, gf, lf} !== 3'b100) begin failures++; $display("FAIL cmp_flags got=%b exp=100", {zf, gf, lf}); end
    checks++; if (dest_reg_write_en !== 1'b0) begin failures++; $display("FAIL cmp_we got=%0b exp=0", dest_reg_write_en); end
    checks++; if (result_out !== 16'h0000) begin failures++; $display("FAIL cmp_result got=%h exp=0000", result_out); end
  endtask

  task automatic test_br;
    issue(5'd9, 5'd1, 16'h1234, 16'h5678, 16'h0010, 7'h7E);
    checks++; if (target !== 16'h000E) begin failures++; $display("FAIL br_target got=%h exp=000e", target); end
    checks++; if (result_out !== 16'h0000) begin failures++; $display("FAIL br_result got=%h exp=0000", result_out); end
    checks++; if (dest_reg_write_en !== 1'b0) begin failures++; $display("FAIL br_we got=%0b exp=0", dest_reg_write_en); end
    checks++; if (control_out !== 5'd9) begin failures++; $display("FAIL br_ctl got=%0d exp=9", control_out); end
  endtask

  task automatic test_mul;
    int low, cyc;
    issue(5'd10, 5'd5, 16'd7, 16'd6, 16'h0030, 7'h0);
    low = 0; cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (!in_ready) low++;
      @(posedge clk); #1; cyc++;
    end
    checks++; if (cyc !== 16) begin failures++; $display("FAIL mul_latency got=%0d exp=16", cyc); end
    checks++; if (low !== 16) begin failures++; $display("FAIL mul_in_ready_low got=%0d exp=16", low); end
    checks++; if (result_out !== 16'd42) begin failures++; $display("FAIL mul_result got=%0d exp=42", result_out); end
    checks++; if (dest_index_out !== 5'd5 || dest_reg_write_en !== 1'b1) begin
      failures++; $display("FAIL mul_dest_we got=%0d/%0b exp=5/1", dest_index_out, dest_reg_write_en);
    end
    checks++; if ({zf, gf, lf} !== 3'b100) begin failures++; $display("FAIL mul_flags_held got=%b exp=100", {zf, gf, lf}); end
    issue(5'd10, 5'd6, 16'h0100, 16'h0100, 16'h0034, 7'h0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    checks++; if (out_valid !== 1'b1 || result_out !== 16'h0000) begin
      failures++; $display("FAIL mul_overflow got=%0b/%h exp=1/0000", out_valid, result_out);
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    c0 = consumed;
    issue(5'd0, 5'd6, 16'd1, 16'd1, 16'h0040, 7'h0);
    control_in = 5'd0; dest_index_in = 5'd7; reg1_data = 16'd3; reg2_data = 16'd4;
    npc = 16'h0044; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result_out !== 16'd2 || dest_index_out !== 5'd6 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_hold got=%0d/%0d/%0b/%0b exp=2/6/1/0", result_out, dest_index_out, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (result_out !== 16'd7 || dest_index_out !== 5'd7 || out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_second got=%0d/%0d/%0b exp=7/7/1", result_out, dest_index_out, out_valid);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
    checks++; if (consumed - c0 !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", consumed - c0); end
  endtask

  task automatic test_reset_mid_mul;
    logic seen;
    issue(5'd10, 5'd9, 16'd7, 16'd6, 16'h0050, 7'h0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || result_out !== 16'h0 || target !== 16'h0) begin
      failures++; $display("FAIL mrst_data got=%0b/%h/%h exp=0/0000/0000", out_valid, result_out, target);
    end
    checks++; if (control_out !== 5'd0 || dest_index_out !== 5'd0 || dest_reg_write_en !== 1'b0 || {zf, gf, lf} !== 3'b000) begin
      failures++; $display("FAIL mrst_side got=%0d/%0d/%0b/%b exp=0/0/0/000", control_out, dest_index_out, dest_reg_write_en, {zf, gf, lf});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready got=%0b exp=1", in_ready); end
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mrst_discard got=%0b exp=0", seen); end
    issue(5'd1, 5'd2, 16'd10, 16'd3, 16'h0060, 7'h0);
    checks++; if (out_valid !== 1'b1 || result_out !== 16'd7 || {zf, gf, lf} !== 3'b010) begin
      failures++; $display("FAIL mrst_sub got=%0b/%0d/%b exp=1/7/010", out_valid, result_out, {zf, gf, lf});
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add_cmp();
    test_br();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
# execute_unit

Parametrised execute stage for the pipelined core. It takes decoded operands, immediate and NPC from the decode/register-read stage, computes the ALU result, branch target and compare flags, and registers them for the memory/writeback stage. Flow control uses valid/ready handshakes in both directions. Multiplication runs as an iterative multi-cycle operation that stalls the upstream stage.

## Interface
- DATA_W, 16, operand/result/NPC width (≥4, power of two)
- IDX_W, 5, destination register index width
- IMM_W, 7, immediate width (sign-extended to DATA_W)
- OP_W, 5, control/opcode width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  unit accepts the instruction this cycle
- control_in  in  OP_W  opcode
- dest_index_in  in  IDX_W  destination register index
- reg1_data, reg2_data  in  DATA_W  source operands
- npc  in  DATA_W  next-PC of the instruction
- immediate  in  IMM_W  signed immediate
- out_valid  out  1  registered result valid
- out_ready  in  1  downstream consumes the result
- control_out  out  OP_W  opcode passed through
- dest_index_out  out  IDX_W  destination index passed through
- result_out  out  DATA_W  ALU result
- target  out  DATA_W  branch target
- dest_reg_write_en  out  1  result is to be written to dest_index_out
- zf, gf, lf  out  1  zero, signed greater, signed less

## Operation
- Opcodes (shared package): ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, ADDI 7, CMP 8, BR 9, MUL 10. All other codes are NOP.
- ADD/SUB/ADDI wrap modulo 2^DATA_W. ADDI = reg1 + sext(immediate).
- SLL/SRL shift by reg2[log2(DATA_W)-1:0]. SRL is logical.
- MUL returns the low DATA_W bits of reg1*reg2.
- BR: target = npc + sext(immediate), result_out = 0. For all other ops, target = npc.
- dest_reg_write_en = 1 for ADD, SUB, AND, OR, XOR, SLL, SRL, ADDI, MUL. It is 0 for CMP, BR and NOP.
- Flags are updated only by SUB and CMP:
  - zf = (reg1 == reg2)
  - gf = signed(reg1) > signed(reg2)
  - lf = signed(reg1) < signed(reg2)
- Flags are held through all other ops. CMP result_out = reg1 − reg2.
- FSM states:
  - IDLE: accepts an instruction when in_valid && in_ready.
    - Non-MUL op: loads the output register and stays in IDLE.
    - MUL: latches operands, dest and control, then goes to MUL_BUSY.
  - MUL_BUSY: shift-add one bit per cycle under a counter from 0 to DATA_W−1. At the last step it loads the output register and returns to IDLE.
- in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational and never depends on in_valid.
- Output register:
  - Set when a result is loaded.
  - Cleared when out_valid && out_ready && no new load.
  - Load and consume in the same cycle: the new result replaces the old one and out_valid stays 1.
- While out_valid && !out_ready, every output is held stable.
- Reset, including mid-MUL: state goes to IDLE, counter to 0, and all outputs to 0 (out_valid, result_out, target, control_out, dest_index_out, dest_reg_write_en, zf, gf, lf). The partial product is discarded.

## Timing
- Single-cycle ops: accepted at edge N, out_valid and outputs valid after edge N. Latency is 1 cycle. Throughput is 1 per cycle when out_ready = 1.
- MUL: accepted at edge N, out_valid after edge N+DATA_W. in_ready is 0 for cycles N+1 … N+DATA_W.
- MUL completion blocked by downstream (out_valid && !out_ready at the final step): the FSM waits in MUL_BUSY on the final count until the output register frees, so no result is lost.
- Flags change on the same edge that loads the SUB/CMP result.

## Structure
- Package exec_pkg:
  - opcode localparams
  - FSM state enum {IDLE, MUL_BUSY}
  - sext helper function
- Sub-module mul_iter, parametrised by DATA_W:
  - inputs start, a, b
  - outputs busy, done, product
  - contains the shift-add datapath and cycle counter
- execute_unit holds the combinational ALU, the FSM and the output register.

## Test plan
- SUB, reg1 = 10, reg2 = 3, dest = 2: one cycle later result_out = 7, dest_index_out = 2, dest_reg_write_en = 1, gf = 1, zf = 0, lf = 0.
- ADD 0xFFFF + 0x0001, then CMP 5 vs 5: result_out = 0x0000 and flags unchanged by the ADD; then zf = 1 and dest_reg_write_en = 0.
- BR, npc = 0x0010, immediate = 7'h7E: target = 0x000E, result_out = 0, dest_reg_write_en = 0.
- MUL 7 × 6 (DATA_W = 16): in_ready low for 16 cycles, then result_out = 42 with out_valid = 1. MUL 0x0100 × 0x0100 gives 0x0000.
- Back-to-back ADDs with out_ready held 0 for 3 cycles: outputs hold stable, in_ready = 0, and no result is dropped or duplicated once out_ready = 1.
- Assert rst_n low at MUL cycle 5: all outputs are 0 immediately. After release, in_ready = 1, and a new SUB 10 − 3 completes normally.
